// File: rtl/intr_arbiter_if.sv
// intr_arbiter_if -- handshake between the interrupt arbiter and the control unit.
//
// Signals:
//   intr_valid    arbiter -> CU  interrupt is being presented
//   excepCode     arbiter -> CU  IVOR number of the presented interrupt
//   intrEntryAddr arbiter -> CU  handler entry address, big-endian bit order [0:31]
//   cu_ack        CU -> arbiter  CU accepts the presented interrupt
//
// Modports: master = arbiter side, slave = control-unit side.
interface intr_arbiter_if;
   logic        intr_valid;
   logic [3:0]  excepCode;
   logic [0:31] intrEntryAddr;
   logic        cu_ack;

   modport master (
      output intr_valid,
      output excepCode,
      output intrEntryAddr,
      input  cu_ack
   );

   modport slave (
      input  intr_valid,
      input  excepCode,
      input  intrEntryAddr,
      output cu_ack
   );
endinterface

// File: rtl/intr_arbiter.sv
// intr_arbiter -- fixed-priority interrupt arbiter with IVOR lookup and a
// PEND/ACK handshake towards the control unit.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   req[7:0]  level requests: 0 DTLB, 1 DSI, 2 ITLB, 3 ISI, 4 progErr, 5 SC, 6 DEV0, 7 DEV1
//   src_ack   one-hot, one-cycle acknowledge to the serviced source
//   MSR[0:31] machine state; MSR[16] (EE) enables DEV0/DEV1
//   IVPR[0:15] interrupt vector prefix
//   ivor_idx  IVOR number requested from the SPR file (non-zero only in LOOKUP)
//   ivor_rd   IVOR contents for ivor_idx, returned combinationally
//   busy      high whenever the arbiter is not idle
//   cu        control-unit handshake (intr_arbiter_if.master)
//
// Build option: define INTR_RR_DEV_EN to arbitrate DEV0/DEV1 round-robin;
// without it DEV0 always beats DEV1.
module intr_arbiter (
   input  logic           clk,
   input  logic           rst,
   input  logic [7:0]     req,
   output logic [7:0]     src_ack,
   input  logic [0:31]    MSR,
   input  logic [0:15]    IVPR,
   output logic [3:0]     ivor_idx,
   input  logic [0:31]    ivor_rd,
   output logic           busy,
   intr_arbiter_if.master cu
);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      PEND,
      ACK,
      DROP
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  elig;
   logic [2:0]  winner;
   logic [3:0]  ivor_num;
   logic        dev1_first;
   logic        unused_ok;

   // Only EE and the IVOR offset field are consumed.
   assign unused_ok = ^{MSR[0:15], MSR[17:31], ivor_rd[0:15], ivor_rd[28:31]};

   // DEV requests are masked, not cleared, while EE is off.
   assign elig = req & {MSR[16], MSR[16], 6'b111111};

   function automatic logic [2:0] pick_winner(input logic [7:0] e, input logic dev1_pref);
      logic [2:0] w;
      casez (e[5:0])
         6'b?????1: w = 3'd0;
         6'b????10: w = 3'd1;
         6'b???100: w = 3'd2;
         6'b??1000: w = 3'd3;
         6'b?10000: w = 3'd4;
         6'b100000: w = 3'd5;
         default: begin
            if (e[7] && (!e[6] || dev1_pref))
               w = 3'd7;
            else
               w = 3'd6;
         end
      endcase
      return w;
   endfunction

   function automatic logic [3:0] ivor_of(input logic [2:0] src);
      logic [3:0] n;
      case (src)
         3'd0:    n = 4'd13;
         3'd1:    n = 4'd2;
         3'd2:    n = 4'd14;
         3'd3:    n = 4'd3;
         3'd4:    n = 4'd6;
         3'd5:    n = 4'd8;
         3'd6:    n = 4'd4;
         default: n = 4'd10;
      endcase
      return n;
   endfunction

`ifdef INTR_RR_DEV_EN
   // rr_ptr = 1 means DEV1 is favoured the next time both devices compete.
   logic rr_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rr_ptr <= 1'b0;
      else if (state == ACK && winner[2:1] == 2'b11)
         rr_ptr <= (winner == 3'd6);
   end

   assign dev1_first = rr_ptr;
`else
   assign dev1_first = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|elig) state_nxt = LOOKUP;
         LOOKUP:  state_nxt = PEND;
         PEND:    if (cu.cu_ack) state_nxt = ACK;
         ACK:     state_nxt = DROP;
         // Wait for the serviced level request to be withdrawn.
         DROP:    if (!req[winner]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---- arbitration: winner latched on leaving IDLE ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         winner   <= 3'd0;
         ivor_num <= 4'd0;
      end else if (state == IDLE && (|elig)) begin
         winner   <= pick_winner(elig, dev1_first);
         ivor_num <= ivor_of(pick_winner(elig, dev1_first));
      end
   end

   // ---- lookup: IVOR read captured into the presented vector ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cu.excepCode     <= 4'd0;
         cu.intrEntryAddr <= 32'd0;
      end else if (state == LOOKUP) begin
         cu.excepCode     <= ivor_num;
         cu.intrEntryAddr <= {IVPR, ivor_rd[16:27], 4'b0000};
      end
   end

   always_comb begin
      ivor_idx      = 4'd0;
      src_ack       = 8'd0;
      cu.intr_valid = 1'b0;
      busy          = (state != IDLE);
      case (state)
         LOOKUP:  ivor_idx      = ivor_num;
         PEND:    cu.intr_valid = 1'b1;
         ACK:     src_ack       = 8'd1 << winner;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_intr_arbiter.sv
// tb_intr_arbiter -- scoreboard bench for intr_arbiter.
// Stimulus predicts each serviced interrupt from the priority rules and pushes
// the expectation; a negedge monitor pops it when intr_valid rises and checks
// the presented vector and the later src_ack.
module tb_intr_arbiter;

   typedef struct packed {
      logic [3:0]  code;
      logic [31:0] addr;
      logic [7:0]  ack;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  req;
   logic [7:0]  src_ack;
   logic [0:31] msr;
   logic [0:15] ivpr;
   logic [3:0]  ivor_idx;
   logic [0:31] ivor_rd;
   logic        busy;
   logic [0:31] tab [16];

   int   errors = 0;
   int   checks = 0;
   bit   model_ptr = 1'b0;   // 1: DEV1 favoured next (round-robin builds only)
   exp_t sb [$];

   const int IVOR_MAP [8] = '{13, 2, 14, 3, 6, 8, 4, 10};

   intr_arbiter_if ifc ();

   intr_arbiter dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .src_ack  (src_ack),
      .MSR      (msr),
      .IVPR     (ivpr),
      .ivor_idx (ivor_idx),
      .ivor_rd  (ivor_rd),
      .busy     (busy),
      .cu       (ifc)
   );

   assign ivor_rd = tab[ivor_idx];

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   // Reference model: eligibility mask, fixed order, optional DEV round-robin.
   task automatic predict_push(input logic [7:0] r, input bit ee, output int w);
      logic [7:0]  e;
      logic [0:31] t;
      exp_t        x;
      e = r & {ee, ee, 6'h3f};
      w = -1;
      for (int i = 0; i < 6; i++)
         if (w < 0 && e[i]) w = i;
      if (w < 0) begin
         if (e[6] && e[7]) w = model_ptr ? 7 : 6;
         else if (e[6])    w = 6;
         else if (e[7])    w = 7;
      end
      if (w >= 0) begin
`ifdef INTR_RR_DEV_EN
         if (w >= 6) model_ptr = (w == 6);
`endif
         t      = tab[IVOR_MAP[w]];
         x.code = 4'(IVOR_MAP[w]);
         x.addr = {ivpr, t[16:27], 4'h0};
         x.ack  = 8'd1 << w;
         sb.push_back(x);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) fail_now("wait_idle_timeout");
   endtask

   task automatic wait_ack();
      int n = 0;
      while (src_ack == 8'd0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (src_ack == 8'd0) fail_now("wait_src_ack_timeout");
   endtask

   // One serviced interrupt, issued from IDLE at a negedge.
   task automatic txn(input logic [7:0] r, input bit ee, input int ack_dly,
                      input int hold, input bit early_drop);
      int w;
      wait_idle();
      msr[16] = ee;
      predict_push(r, ee, w);
      if (w < 0) begin
         fail_now("txn_no_eligible_request");
         return;
      end
      ifc.cu_ack = (ack_dly == 0);
      req = r;
      @(negedge clk);
      chk("lookup_valid_low", 32'(ifc.intr_valid), 32'd0);
      chk("lookup_ivor_idx", 32'(ivor_idx), 32'(IVOR_MAP[w]));
      @(negedge clk);
      chk("latency_valid", 32'(ifc.intr_valid), 32'd1);
      if (early_drop) req = 8'h00;
      for (int i = 1; i < ack_dly; i++) begin
         chk("pend_no_ack", 32'(src_ack), 32'd0);
         @(negedge clk);
         chk("pend_valid_held", 32'(ifc.intr_valid), 32'd1);
      end
      ifc.cu_ack = 1'b1;
      wait_ack();
      ifc.cu_ack = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("drop_busy", 32'(busy), 32'd1);
         chk("drop_no_valid", 32'(ifc.intr_valid), 32'd0);
      end
      req = 8'h00;
   endtask

   // Monitor: pops on intr_valid rising, checks vector and acknowledge.
   initial begin
      exp_t cur;
      bit   cur_v   = 1'b0;
      bit   prev_iv = 1'b0;
      logic [7:0] prev_ack = 8'd0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cur_v    = 1'b0;
            prev_iv  = 1'b0;
            prev_ack = 8'd0;
            chk("reset_src_ack", 32'(src_ack), 32'd0);
            chk("reset_valid", 32'(ifc.intr_valid), 32'd0);
         end else begin
            if (ifc.intr_valid && !prev_iv) begin
               if (sb.size() == 0) fail_now("unexpected_intr_valid");
               else begin
                  cur   = sb.pop_front();
                  cur_v = 1'b1;
               end
            end
            if (ifc.intr_valid && cur_v) begin
               chk("excepCode", 32'(ifc.excepCode), 32'(cur.code));
               chk("intrEntryAddr", ifc.intrEntryAddr, cur.addr);
            end
            if (src_ack != 8'd0) begin
               chk("src_ack_one_cycle", 32'(prev_ack), 32'd0);
               chk("ack_valid_low", 32'(ifc.intr_valid), 32'd0);
               if (cur_v) begin
                  chk("src_ack", 32'(src_ack), 32'(cur.ack));
                  cur_v = 1'b0;
               end else fail_now("unexpected_src_ack");
            end
            if (!busy) chk("idle_ivor_idx", 32'(ivor_idx), 32'd0);
            prev_iv  = ifc.intr_valid;
            prev_ack = src_ack;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog_timeout (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [7:0] r;
      bit ee;
      int ack_dly, hold;
      bit early;

      rst        = 1'b0;
      req        = 8'h00;
      msr        = '0;
      ivpr       = '0;
      ifc.cu_ack = 1'b0;
      for (int i = 0; i < 16; i++) tab[i] = $urandom;
      #1;
      chk("rst_src_ack", 32'(src_ack), 32'd0);
      chk("rst_valid", 32'(ifc.intr_valid), 32'd0);
      chk("rst_excepCode", 32'(ifc.excepCode), 32'd0);
      chk("rst_addr", ifc.intrEntryAddr, 32'd0);
      chk("rst_ivor_idx", 32'(ivor_idx), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // DEV0 basic vector and latency
      ivpr   = 16'h0001;
      tab[4] = 32'h0000_0120;
      txn(8'h40, 1'b1, 1, 0, 1'b0);
      chk("dev0_code_hold", 32'(ifc.excepCode), 32'd4);
      chk("dev0_addr_hold", ifc.intrEntryAddr, 32'h0001_0120);

      // DSI beats progErr; progErr follows once DSI drops
      wait_idle();
      msr[16]    = 1'b1;
      predict_push(8'h12, 1'b1, w);
      ifc.cu_ack = 1'b1;
      req        = 8'h12;
      wait_ack();
      predict_push(8'h10, 1'b1, w);
      req = 8'h10;
      @(negedge clk);
      wait_ack();
      ifc.cu_ack = 1'b0;
      req = 8'h00;
      chk("progErr_second_code", 32'(ifc.excepCode), 32'd6);

      // long PEND without cu_ack, then request held through DROP
      txn(8'h20, 1'b1, 11, 4, 1'b0);

      // reset during PEND abandons the interrupt; request re-arbitrated after
      wait_idle();
      msr[16]    = 1'b1;
      predict_push(8'h08, 1'b1, w);
      ifc.cu_ack = 1'b0;
      req        = 8'h08;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_valid", 32'(ifc.intr_valid), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_code", 32'(ifc.excepCode), 32'd0);
      chk("async_rst_addr", ifc.intrEntryAddr, 32'd0);
      chk("async_rst_src_ack", 32'(src_ack), 32'd0);
      @(negedge clk);
      model_ptr = 1'b0;
      predict_push(8'h08, 1'b1, w);
      rst        = 1'b1;
      ifc.cu_ack = 1'b1;
      wait_ack();
      ifc.cu_ack = 1'b0;
      req = 8'h00;

      // EE off masks both devices; enabling EE services DEV0 first
      wait_idle();
      msr[16] = 1'b0;
      req     = 8'hC0;
      repeat (10) begin
         @(negedge clk);
         chk("ee_off_busy", 32'(busy), 32'd0);
      end
      txn(8'hC0, 1'b1, 1, 0, 1'b0);
      chk("ee_on_dev0_first", 32'(ifc.excepCode), 32'd4);

      // both devices repeatedly re-raised
      for (int k = 0; k < 4; k++) txn(8'hC0, 1'b1, 0, 0, 1'b0);

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         r  = 8'($urandom);
         ee = 1'($urandom_range(0, 1));
         if (r == 8'h00) r = 8'h01 << $urandom_range(0, 7);
         if ((r & {ee, ee, 6'h3f}) == 8'h00) ee = 1'b1;
         if ($urandom_range(0, 3) == 0) ivpr = 16'($urandom);
         if ($urandom_range(0, 3) == 0)
            for (int i = 0; i < 16; i++) tab[i] = $urandom;
         ack_dly = $urandom_range(0, 4);
         early   = ($urandom_range(0, 3) == 0);
         hold    = early ? 0 : $urandom_range(0, 3);
         txn(r, ee, ack_dly, hold, early);
      end

      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/intr_arbiter.md
INTR_ARBITER -- requirements
Module: intr_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 req  input  8  level interrupt requests; bit0 DTLB, 1 DSI, 2 ITLB, 3 ISI, 4 progErr, 5 SC, 6 DEV0, 7 DEV1.
REQ-004 src_ack  output  8  one-hot, one-cycle acknowledge to the winning source.
REQ-005 MSR  input  32 [0:31]  machine state; MSR[16] (EE) gates DEV0/DEV1.
REQ-006 IVPR  input  16 [0:15]  interrupt vector prefix.
REQ-007 ivor_idx  output  4  IVOR number to read from the SPR file.
REQ-008 ivor_rd  input  32 [0:31]  IVOR contents returned combinationally for ivor_idx.
REQ-009 intr_valid  output  1  interrupt presented to CU.
REQ-010 excepCode  output  4  IVOR number of the presented interrupt.
REQ-011 intrEntryAddr  output  32 [0:31]  handler entry address.
REQ-012 cu_ack  input  1  CU accepts the presented interrupt.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 IVOR map: DTLB 13, DSI 2, ITLB 14, ISI 3, progErr 6, SC 8, DEV0 4, DEV1 10.
REQ-015 Eligible = req & {MSR[16], MSR[16], 6'b111111} (bit7..0); DEV requests ignored while EE=0, never dropped.
REQ-016 Fixed priority, bit0 highest, bit7 lowest, except DEV0/DEV1 ordering per REQ-027.
REQ-017 FSM states: IDLE, LOOKUP, PEND, ACK, DROP.
REQ-018 IDLE: if any eligible bit, latch winner index and IVOR number, go LOOKUP; else stay.
REQ-019 LOOKUP (1 cycle): ivor_idx = latched IVOR number; capture ivor_rd at end of cycle; go PEND.
REQ-020 PEND: intr_valid=1, excepCode and intrEntryAddr stable; intrEntryAddr = {IVPR[0:15], ivor_rd[16:27], 4'b0000}, registered.
REQ-021 PEND exits to ACK on the first edge where cu_ack=1; cu_ack outside PEND is ignored.
REQ-022 ACK (1 cycle): src_ack[winner]=1, all other src_ack bits 0; intr_valid=0; go DROP.
REQ-023 DROP: stay until req[winner]=0, then IDLE; prevents re-servicing a level request not yet withdrawn.
REQ-024 Winner is latched: req[winner] falling during LOOKUP/PEND does not abort; sequence completes.
REQ-025 New or higher-priority requests arriving after IDLE are not preempting; arbitrated on next IDLE.
REQ-026 Minimum latency: req high in IDLE cycle N -> intr_valid high in cycle N+2; IDLE-to-IDLE minimum 5 cycles (cu_ack tied high, req dropped on src_ack).
REQ-027 DEV order: DEV0 above DEV1 unless REQ-030 applies.
REQ-028 ivor_idx = 0 outside LOOKUP; excepCode, intrEntryAddr hold last values outside PEND.

Reset
REQ-029 rst=0 immediately (asynchronous) forces IDLE and outputs src_ack=0, intr_valid=0, excepCode=0, intrEntryAddr=0, ivor_idx=0, busy=0, winner=0, RR pointer=DEV0; reset mid-sequence abandons the interrupt with no src_ack.

Configuration
REQ-030 INTR_RR_DEV_EN defined: DEV0/DEV1 round-robin; a 1-bit pointer toggles to the other device after each serviced device interrupt (at ACK); when both eligible, the pointed-to device wins. Undefined: fixed DEV0 > DEV1, no pointer register.

Verification
REQ-031 MSR[16]=1, IVPR=16'h0001, ivor_rd=32'h0000_0120, req=8'h40 in cycle N -> intr_valid=1 at N+2, excepCode=4, intrEntryAddr=32'h0001_0120; cu_ack -> src_ack=8'h40 one cycle.
REQ-032 req=8'h12 (DSI+progErr) simultaneous -> DSI wins, excepCode=2; after DSI drops, progErr serviced, excepCode=6.
REQ-033 MSR[16]=0, req=8'hC0 -> busy stays 0 indefinitely; set MSR[16]=1 -> DEV0 serviced first (excepCode=4).
REQ-034 cu_ack held 0 for 10 cycles in PEND -> intr_valid and outputs stable, no src_ack; req held high after ACK -> FSM stays DROP, no second intr_valid.
REQ-035 rst pulled low during PEND -> intr_valid=0 same cycle, no src_ack; after release, still-pending request re-arbitrated from IDLE.
REQ-036 INTR_RR_DEV_EN defined, req=8'hC0 held with immediate drop/re-raise -> excepCode alternates 4,10,4,10; undefined -> always 4.
